state_streamer: RTL and testbench
=================================

Name: state_streamer

Overview:
Snapshots a wide internal cracker state vector on request and streams it out as a framed byte sequence over an 8-bit port with a valid/ack handshake. It generalises the fixed give_state output mux. While idle, the output port carries a live byte such as the current password byte. While streaming, it carries the framed snapshot, and hold_target tells the producer to freeze. Frame length, header value and checksum inclusion are parametrised. Abort and back-pressure are supported.

Parameters:
STATE_BYTES, 64, number of state bytes per frame (>=1); state_in width is STATE_BYTES*8.
HEADER_BYTE, 8'hA5, first byte of every frame.
SEND_CHECKSUM, 1, 1 = append checksum byte after data; 0 = no checksum byte.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
live_byte  input  8  byte passed through to output_byte while idle.
start  input  1  request a snapshot and frame; sampled only in IDLE.
abort  input  1  cancel an in-progress frame.
state_in  input  STATE_BYTES*8  state vector; byte k = state_in[8k+7:8k].
ack  input  1  consumer accepts the current byte when sampled with byte_valid=1.
output_byte  output  8  registered output byte.
byte_valid  output  1  output_byte holds a frame byte.
busy  output  1  frame in progress.
hold_target  output  1  equal to busy; producer must not advance while high.
done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (async, any state): state=IDLE; snapshot register=0; byte counter=0; checksum accumulator=0. Outputs: output_byte=0, byte_valid=0, busy=0, hold_target=0, done=0.
- States: IDLE, HEADER, DATA, CSUM, FINISH.
- IDLE:
  - output_byte <= live_byte every edge (1-cycle latency); byte_valid=0; busy=0.
  - start=1 and abort=0 at an edge: snapshot <= state_in; counter <= 0; acc <= 0; go to HEADER.
  - abort has priority over a simultaneous start: stay in IDLE.
- HEADER: entered with output_byte=HEADER_BYTE, byte_valid=1, busy=1. Ack -> DATA, with output_byte=snapshot byte 0.
- DATA:
  - Presents snapshot byte[counter]; bytes are sent LSB-first (byte 0 first).
  - On ack: acc <= acc + byte, mod 256.
  - If counter < STATE_BYTES-1: counter increments and the next byte is presented the following cycle.
  - Otherwise: go to CSUM if SEND_CHECKSUM=1, else FINISH.
- CSUM:
  - Presents (0 - acc) mod 256, so the sum of all data bytes plus the checksum is 0 mod 256.
  - Ack -> FINISH.
- FINISH: a single cycle with done=1, busy=0, byte_valid=0. Then IDLE; live_byte passthrough resumes at the next edge.
- Handshake:
  - A byte transfers at a rising edge where byte_valid=1 and ack=1.
  - With ack held high, one byte transfers per cycle with no bubbles.
  - With ack low, output_byte and byte_valid hold unchanged indefinitely.
  - ack with byte_valid=0 is ignored.
- Snapshot isolation: state_in changes after the start edge do not affect the frame in flight.
- start while busy or in FINISH: ignored; no queuing.
- abort in HEADER/DATA/CSUM:
  - Next edge goes to IDLE with byte_valid=0, busy=0, and no done pulse.
  - An abort coinciding with the final ack also wins: no done pulse.
- Counter width: $clog2(STATE_BYTES+1); no wrap occurs within a frame.
- Frame length: 1 + STATE_BYTES + SEND_CHECKSUM bytes.

Test Plan:
1. Reset/idle: assert rst mid-DATA -> all outputs 0 immediately. Release, drive live_byte=8'h3C -> output_byte=8'h3C one cycle later, byte_valid=0, busy=0.
2. Full frame (STATE_BYTES=4, SEND_CHECKSUM=1):
   - Stimulus: state_in=32'h04030201, start pulse, ack held high.
   - Required: output sequence A5, 01, 02, 03, 04, F6 on consecutive cycles; done pulses once on the cycle after F6 is accepted; busy is high for exactly 6 cycles.
3. Back-pressure: drop ack for 5 cycles while byte 02 is presented -> output_byte stays 02 with byte_valid=1. Change state_in to 0 during the stall -> the remaining bytes are still 03, 04, F6.
4. Abort: assert abort while byte 03 is presented -> next cycle IDLE, byte_valid=0, no done. A new start then yields a fresh frame beginning with A5.
5. Start collisions:
   - start held high through a whole frame -> exactly one frame, then a new frame starts after FINISH.
   - start and abort both high in IDLE -> no frame.
6. SEND_CHECKSUM=0, STATE_BYTES=1, state_in=8'hFF -> output A5, FF, then done; no checksum byte.

Source files
------------

// File: rtl/state_streamer_if.sv
// Handshake and data bundle between the state streamer and its
// producer/consumer side; master is the streamer itself.
interface state_streamer_if #(
   parameter int STATE_BYTES = 64
);
   logic [7:0]               live_byte;
   logic                     start;
   logic                     abort;
   logic [STATE_BYTES*8-1:0] state_in;
   logic                     ack;
   logic [7:0]               output_byte;
   logic                     byte_valid;
   logic                     busy;
   logic                     hold_target;
   logic                     done;

   modport master (
      input  live_byte, start, abort, state_in, ack,
      output output_byte, byte_valid, busy, hold_target, done
   );

   modport slave (
      output live_byte, start, abort, state_in, ack,
      input  output_byte, byte_valid, busy, hold_target, done
   );
endinterface

// File: rtl/state_streamer.sv
// Snapshots a wide state vector and streams it as a framed byte
// sequence: header, data bytes LSB-first, optional checksum.
module state_streamer #(
   parameter int         STATE_BYTES   = 64,
   parameter logic [7:0] HEADER_BYTE   = 8'hA5,
   parameter bit         SEND_CHECKSUM = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   state_streamer_if.master bus
);
   localparam int W  = STATE_BYTES * 8;
   localparam int CW = $clog2(STATE_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(STATE_BYTES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HEADER = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CSUM   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [W-1:0]  snap_q, snap_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [7:0]    acc_q, acc_d, acc_sum;
   logic [7:0]    obyte_q, obyte_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          busy;

   assign busy = (state_q == S_HEADER) ||
                 (state_q == S_DATA) ||
                 (state_q == S_CSUM);

   always_comb begin
      cnt_nxt = cnt_q + ONE;
      acc_sum = acc_q + obyte_q;
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      obyte_d = obyte_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            obyte_d = bus.live_byte;
            if (bus.start && !bus.abort) begin
               state_d = S_HEADER;
               snap_d  = bus.state_in;
               cnt_d   = '0;
               acc_d   = '0;
               obyte_d = HEADER_BYTE;
               valid_d = 1'b1;
            end
         end
         S_HEADER: begin
            if (bus.ack) begin
               state_d = S_DATA;
               obyte_d = snap_q[7:0];
            end
         end
         S_DATA: begin
            if (bus.ack) begin
               acc_d = acc_sum;
               if (cnt_q != LAST) begin
                  cnt_d   = cnt_nxt;
                  obyte_d = 8'(snap_q >> {cnt_nxt, 3'b000});
               end else if (SEND_CHECKSUM) begin
                  state_d = S_CSUM;
                  obyte_d = 8'h00 - acc_sum;
               end else begin
                  state_d = S_FINISH;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_CSUM: begin
            if (bus.ack) begin
               state_d = S_FINISH;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // abort beats any ack on the same edge, including the last one
      if (busy && bus.abort) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
         obyte_d = bus.live_byte;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         obyte_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         obyte_q <= obyte_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign bus.output_byte = obyte_q;
   assign bus.byte_valid  = valid_q;
   assign bus.busy        = busy;
   assign bus.hold_target = busy;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_state_streamer.sv
// Directed bench: a 4-byte checksummed streamer and a 1-byte
// streamer without checksum, driven by one linear step sequence.
module tb_state_streamer;
   logic clk = 1'b0;
   logic rst;
   int   errs   = 0;
   int   checks = 0;

   state_streamer_if #(.STATE_BYTES(4)) a_if ();
   state_streamer_if #(.STATE_BYTES(1)) b_if ();

   state_streamer #(
      .STATE_BYTES(4), .HEADER_BYTE(8'hA5), .SEND_CHECKSUM(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(a_if.master)
   );

   state_streamer #(
      .STATE_BYTES(1), .HEADER_BYTE(8'hA5), .SEND_CHECKSUM(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(b_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // status of streamer A: valid, busy, hold_target, done
   task automatic st_a(input string tag, input logic v,
                       input logic b, input logic d);
      chk({tag, ".valid"}, 32'(a_if.byte_valid), 32'(v));
      chk({tag, ".busy"}, 32'(a_if.busy), 32'(b));
      chk({tag, ".hold"}, 32'(a_if.hold_target), 32'(b));
      chk({tag, ".done"}, 32'(a_if.done), 32'(d));
   endtask

   task automatic byte_a(input string tag, input logic [7:0] e);
      chk({tag, ".byte"}, 32'(a_if.output_byte), 32'(e));
      st_a(tag, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      logic [7:0] fr [6];
      int nbusy;
      int ndone;
      fr[0] = 8'hA5; fr[1] = 8'h01; fr[2] = 8'h02;
      fr[3] = 8'h03; fr[4] = 8'h04; fr[5] = 8'hF6;

      rst = 1'b1;
      a_if.live_byte = 8'h00; a_if.start = 1'b0;
      a_if.abort = 1'b0; a_if.state_in = '0; a_if.ack = 1'b0;
      b_if.live_byte = 8'h00; b_if.start = 1'b0;
      b_if.abort = 1'b0; b_if.state_in = '0; b_if.ack = 1'b0;
      #2;
      chk("rst.byte", 32'(a_if.output_byte), 32'h0);
      st_a("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.b_valid", 32'(b_if.byte_valid), 32'h0);
      #20 rst = 1'b0;

      // full frame with ack held high
      a_if.state_in = 32'h04030201;
      a_if.ack = 1'b1;
      a_if.start = 1'b1;
      nbusy = 0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 0) a_if.start = 1'b0;
         nbusy += int'(a_if.busy);
         ndone += int'(a_if.done);
         if (i < 6) byte_a($sformatf("frame%0d", i), fr[i]);
         if (i == 6) st_a("frame.fin", 1'b0, 1'b0, 1'b1);
      end
      chk("frame.busy_cycles", 32'(nbusy), 32'd6);
      chk("frame.done_pulses", 32'(ndone), 32'd1);

      // back-pressure on byte 02, state_in changed mid-stall
      a_if.start = 1'b1;
      step(); byte_a("bp.hdr", 8'hA5);
      a_if.start = 1'b0;
      step(); byte_a("bp.b0", 8'h01);
      step(); byte_a("bp.b1", 8'h02);
      a_if.ack = 1'b0;
      a_if.state_in = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         byte_a($sformatf("bp.stall%0d", i), 8'h02);
      end
      a_if.ack = 1'b1;
      step(); byte_a("bp.b2", 8'h03);
      step(); byte_a("bp.b3", 8'h04);
      step(); byte_a("bp.cs", 8'hF6);
      step(); st_a("bp.fin", 1'b0, 1'b0, 1'b1);
      step(); st_a("bp.idle", 1'b0, 1'b0, 1'b0);

      // abort while byte 03 is presented, then a fresh frame
      a_if.state_in = 32'h04030201;
      a_if.start = 1'b1;
      step(); byte_a("ab.hdr", 8'hA5);
      a_if.start = 1'b0;
      step(); step();
      step(); byte_a("ab.b2", 8'h03);
      a_if.abort = 1'b1;
      step(); st_a("ab.cut", 1'b0, 1'b0, 1'b0);
      a_if.abort = 1'b0;
      step(); st_a("ab.idle", 1'b0, 1'b0, 1'b0);
      a_if.start = 1'b1;
      step(); byte_a("ab.new_hdr", 8'hA5);
      a_if.start = 1'b0;
      for (int i = 1; i < 6; i++) begin
         step();
         byte_a($sformatf("ab.new%0d", i), fr[i]);
      end
      step(); st_a("ab.fin", 1'b0, 1'b0, 1'b1);
      step(); st_a("ab.idle2", 1'b0, 1'b0, 1'b0);

      // async reset mid-DATA, then live passthrough
      a_if.start = 1'b1;
      step(); byte_a("rd.hdr", 8'hA5);
      a_if.start = 1'b0;
      step(); byte_a("rd.b0", 8'h01);
      #2 rst = 1'b1;
      #1;
      chk("rd.byte", 32'(a_if.output_byte), 32'h0);
      st_a("rd", 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      a_if.live_byte = 8'h3C;
      step();
      chk("live.byte", 32'(a_if.output_byte), 32'h3C);
      st_a("live", 1'b0, 1'b0, 1'b0);

      // start held high: one frame, next begins after FINISH
      a_if.start = 1'b1;
      ndone = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i < 8) ndone += int'(a_if.done);
         if (i < 6) byte_a($sformatf("sh%0d", i), fr[i]);
         if (i == 6) st_a("sh.fin", 1'b0, 1'b0, 1'b1);
         if (i == 7) st_a("sh.idle", 1'b0, 1'b0, 1'b0);
         if (i == 8) byte_a("sh.again", 8'hA5);
      end
      chk("sh.done_pulses", 32'(ndone), 32'd1);
      a_if.abort = 1'b1;
      step(); st_a("sh.abort", 1'b0, 1'b0, 1'b0);

      // start and abort together in IDLE
      for (int i = 0; i < 3; i++) begin
         step();
         st_a($sformatf("sa%0d", i), 1'b0, 1'b0, 1'b0);
      end
      a_if.start = 1'b0;
      a_if.abort = 1'b0;

      // one data byte, no checksum
      b_if.state_in = 8'hFF;
      b_if.ack = 1'b1;
      b_if.start = 1'b1;
      step();
      b_if.start = 1'b0;
      chk("nc.hdr", 32'(b_if.output_byte), 32'hA5);
      chk("nc.hdr_valid", 32'(b_if.byte_valid), 32'h1);
      step();
      chk("nc.data", 32'(b_if.output_byte), 32'hFF);
      chk("nc.data_valid", 32'(b_if.byte_valid), 32'h1);
      chk("nc.data_busy", 32'(b_if.busy), 32'h1);
      step();
      chk("nc.done", 32'(b_if.done), 32'h1);
      chk("nc.fin_valid", 32'(b_if.byte_valid), 32'h0);
      chk("nc.fin_busy", 32'(b_if.busy), 32'h0);
      step();
      chk("nc.done_off", 32'(b_if.done), 32'h0);
      chk("nc.idle_valid", 32'(b_if.byte_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
